// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: tag/data widths, ALU opcodes, reservation station entry states.
package tomasulo_pkg;

   localparam int unsigned TAG_W  = 4;
   localparam int unsigned DATA_W = 32;

   localparam logic [TAG_W-1:0] NO_TAG = '0;

   typedef enum logic {OP_ADD, OP_SUB} alu_op_e;

   typedef enum logic [1:0] {FREE, WAIT, EXEC, DONE} rs_state_e;

   // 32-bit wrap-around add/sub; no overflow reporting.
   function automatic logic [DATA_W-1:0] alu_exec(alu_op_e op, logic [DATA_W-1:0] a,
                                                  logic [DATA_W-1:0] b);
      return (op == OP_SUB) ? a - b : a + b;
   endfunction

endpackage

// File: rtl/rs_entry.sv
// One adder reservation station entry: operand snoop/bypass, execution countdown and result hold
// until its own tag is seen on the CDB.
module rs_entry
   import tomasulo_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alloc_i,
   input  alu_op_e           op_i,
   input  logic [DATA_W-1:0] vj_i,
   input  logic [DATA_W-1:0] vk_i,
   input  logic [TAG_W-1:0]  qj_i,
   input  logic [TAG_W-1:0]  qk_i,
   input  logic [TAG_W-1:0]  own_tag_i,
   input  logic              cdb_valid_i,
   input  logic [TAG_W-1:0]  cdb_tag_i,
   input  logic [DATA_W-1:0] cdb_data_i,
   output logic              free_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [TAG_W-1:0]  out_tag_o
);

   localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(EXEC_CYCLES - 1);

   rs_state_e         state_q;
   alu_op_e           op_q;
   logic [DATA_W-1:0] vj_q, vk_q, vj_d, vk_d;
   logic [TAG_W-1:0]  qj_q, qk_q, qj_d, qk_d;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] result_q;
   logic              out_valid_q;
   logic [TAG_W-1:0]  out_tag_q;
   logic              grant;

   // A FREE entry snoops the issue operands (bypass); a WAIT entry snoops its own.
   always_comb begin
      qj_d = (state_q == FREE) ? qj_i : qj_q;
      vj_d = (state_q == FREE) ? vj_i : vj_q;
      qk_d = (state_q == FREE) ? qk_i : qk_q;
      vk_d = (state_q == FREE) ? vk_i : vk_q;
      if (cdb_valid_i && qj_d != NO_TAG && cdb_tag_i == qj_d) begin
         qj_d = NO_TAG;
         vj_d = cdb_data_i;
      end
      if (cdb_valid_i && qk_d != NO_TAG && cdb_tag_i == qk_d) begin
         qk_d = NO_TAG;
         vk_d = cdb_data_i;
      end
      grant = cdb_valid_i && own_tag_i != NO_TAG && cdb_tag_i == own_tag_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= FREE;
         op_q        <= OP_ADD;
         vj_q        <= '0;
         vk_q        <= '0;
         qj_q        <= NO_TAG;
         qk_q        <= NO_TAG;
         cnt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= NO_TAG;
      end else begin
         unique case (state_q)
            FREE: begin
               if (alloc_i) begin
                  op_q    <= op_i;
                  vj_q    <= vj_d;
                  vk_q    <= vk_d;
                  qj_q    <= qj_d;
                  qk_q    <= qk_d;
                  cnt_q   <= CntLoad;
                  state_q <= (qj_d == NO_TAG && qk_d == NO_TAG) ? EXEC : WAIT;
               end
            end
            WAIT: begin
               vj_q <= vj_d;
               vk_q <= vk_d;
               qj_q <= qj_d;
               qk_q <= qk_d;
               if (qj_d == NO_TAG && qk_d == NO_TAG) begin
                  cnt_q   <= CntLoad;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q == '0) begin
                  result_q    <= alu_exec(op_q, vj_q, vk_q);
                  out_valid_q <= 1'b1;
                  out_tag_q   <= own_tag_i;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            DONE: begin
               if (grant) begin
                  result_q    <= '0;
                  out_valid_q <= 1'b0;
                  out_tag_q   <= NO_TAG;
                  state_q     <= FREE;
               end
            end
         endcase
      end
   end

   assign free_o      = (state_q == FREE);
   assign out_valid_o = out_valid_q;
   assign out_data_o  = result_q;
   assign out_tag_o   = out_tag_q;

endmodule

// File: rtl/add_rs.sv
// Adder reservation station: NUM_ENTRIES entries, each driving its own CDB adder port, plus a
// lowest-index-free allocator.
module add_rs
   import tomasulo_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 3,
   parameter int unsigned TAG_BASE    = 1,
   parameter int unsigned EXEC_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_op,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic [TAG_W-1:0]  issue_qj,
   input  logic [TAG_W-1:0]  issue_qk,
   output logic              issue_ready,
   output logic [TAG_W-1:0]  issue_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic              cdb_valid,
   output logic [DATA_W-1:0] out_data  [NUM_ENTRIES],
   output logic [TAG_W-1:0]  out_tag   [NUM_ENTRIES],
   output logic              out_valid [NUM_ENTRIES]
);

   logic [NUM_ENTRIES-1:0] free;
   logic [NUM_ENTRIES-1:0] sel;
   logic [NUM_ENTRIES-1:0] alloc;
   logic                   found;

   // Allocation only looks at registered FREE state, so a slot freed this cycle waits one cycle.
   always_comb begin
      sel       = '0;
      found     = 1'b0;
      issue_tag = NO_TAG;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (free[i] && !found) begin
            sel[i]    = 1'b1;
            found     = 1'b1;
            issue_tag = TAG_W'(TAG_BASE + i);
         end
      end
   end

   assign issue_ready = |free;
   assign alloc       = sel & {NUM_ENTRIES{issue_valid}};

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
      rs_entry #(
         .EXEC_CYCLES(EXEC_CYCLES)
      ) u_entry (
         .clk_i      (clk),
         .rst_i      (rst),
         .alloc_i    (alloc[g]),
         .op_i       (alu_op_e'(issue_op)),
         .vj_i       (issue_vj),
         .vk_i       (issue_vk),
         .qj_i       (issue_qj),
         .qk_i       (issue_qk),
         .own_tag_i  (TAG_W'(TAG_BASE + g)),
         .cdb_valid_i(cdb_valid),
         .cdb_tag_i  (cdb_tag),
         .cdb_data_i (cdb_data),
         .free_o     (free[g]),
         .out_valid_o(out_valid[g]),
         .out_data_o (out_data[g]),
         .out_tag_o  (out_tag[g])
      );
   end

endmodule

// File: tb/tb_add_rs.sv
// Bench for add_rs: directed stimulus, expected results queued at issue and matched by a monitor
// whenever an entry raises out_valid, plus directed latency/status checks.
module tb_add_rs;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_op;
   logic [31:0] issue_vj, issue_vk;
   logic [3:0]  issue_qj, issue_qk;
   logic        issue_ready;
   logic [3:0]  issue_tag;
   logic [31:0] cdb_data;
   logic [3:0]  cdb_tag;
   logic        cdb_valid;
   logic [31:0] out_data  [N];
   logic [3:0]  out_tag   [N];
   logic        out_valid [N];

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic prev_v [N];

   always #5 clk = ~clk;

   add_rs #(
      .NUM_ENTRIES(3),
      .TAG_BASE   (1),
      .EXEC_CYCLES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(issue_valid),
      .issue_op   (issue_op),
      .issue_vj   (issue_vj),
      .issue_vk   (issue_vk),
      .issue_qj   (issue_qj),
      .issue_qk   (issue_qk),
      .issue_ready(issue_ready),
      .issue_tag  (issue_tag),
      .cdb_data   (cdb_data),
      .cdb_tag    (cdb_tag),
      .cdb_valid  (cdb_valid),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .out_valid  (out_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] qa, input logic [3:0] qb,
                           input logic [3:0] exp_tag, input logic [31:0] exp_data,
                           input bit push, input string name);
      exp_t e;
      issue_valid = 1'b1;
      issue_op    = op;
      issue_vj    = a;
      issue_vk    = b;
      issue_qj    = qa;
      issue_qk    = qb;
      chk({name, "_issue_tag"}, 32'(issue_tag), 32'(exp_tag));
      if (push) begin
         e.tag  = exp_tag;
         e.data = exp_data;
         sb.push_back(e);
      end
      tick();
      issue_valid = 1'b0;
      issue_qj    = 4'd0;
      issue_qk    = 4'd0;
   endtask

   task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
   endtask

   task automatic bcast_off();
      cdb_valid = 1'b0;
      cdb_tag   = 4'd0;
      cdb_data  = 32'd0;
   endtask

   task automatic grant(input logic [3:0] tag);
      bcast(tag, 32'd0);
      tick();
      bcast_off();
   endtask

   // Monitor: each rising out_valid must match the oldest queued result for that entry's tag.
   initial begin
      for (int i = 0; i < N; i++) prev_v[i] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (out_valid[i] === 1'b1 && prev_v[i] !== 1'b1) begin
               int idx;
               idx = -1;
               for (int k = 0; k < sb.size(); k++)
                  if (idx < 0 && sb[k].tag == 4'(i + 1)) idx = k;
               checks++;
               if (idx < 0) begin
                  errors++;
                  $display("FAIL sb_unexpected entry %0d: got tag %0d data 0x%08h, expected no result",
                           i, out_tag[i], out_data[i]);
               end else begin
                  if (out_tag[i] !== sb[idx].tag || out_data[i] !== sb[idx].data) begin
                     errors++;
                     $display("FAIL sb_result entry %0d: got tag %0d data 0x%08h, expected tag %0d data 0x%08h",
                              i, out_tag[i], out_data[i], sb[idx].tag, sb[idx].data);
                  end
                  sb.delete(idx);
               end
            end
            prev_v[i] = out_valid[i];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst         = 1'b1;
      issue_valid = 1'b0;
      issue_op    = 1'b0;
      issue_vj    = 32'd0;
      issue_vk    = 32'd0;
      issue_qj    = 4'd0;
      issue_qk    = 4'd0;
      bcast_off();
      tick();
      tick();
      rst = 1'b0;

      chk("reset_ready", 32'(issue_ready), 32'd1);
      chk("reset_tag", 32'(issue_tag), 32'd1);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset_valid%0d", i), 32'(out_valid[i]), 32'd0);
         chk($sformatf("reset_data%0d", i), out_data[i], 32'd0);
         chk($sformatf("reset_otag%0d", i), 32'(out_tag[i]), 32'd0);
      end

      // Ready operands: 5+7, visible three cycles after issue.
      do_issue(1'b0, 32'd5, 32'd7, 4'd0, 4'd0, 4'd1, 32'd12, 1'b1, "add");
      chk("add_lat1", 32'(out_valid[0]), 32'd0);
      tick();
      chk("add_lat2", 32'(out_valid[0]), 32'd0);
      tick();
      chk("add_valid", 32'(out_valid[0]), 32'd1);
      chk("add_data", out_data[0], 32'd12);
      chk("add_otag", 32'(out_tag[0]), 32'd1);
      bcast(4'd1, 32'd12);
      chk("grant_cycle_tag", 32'(issue_tag), 32'd2);
      tick();
      bcast_off();
      chk("grant_freed", 32'(out_valid[0]), 32'd0);
      chk("grant_realloc_tag", 32'(issue_tag), 32'd1);

      // Waiting operand: 10-3 once tag 9 is broadcast.
      do_issue(1'b1, 32'd0, 32'd3, 4'd9, 4'd0, 4'd1, 32'd7, 1'b1, "sub_wait");
      tick();
      tick();
      tick();
      chk("wait_hold", 32'(out_valid[0]), 32'd0);
      bcast(4'd9, 32'd10);
      tick();
      bcast_off();
      tick();
      chk("wait_lat2", 32'(out_valid[0]), 32'd0);
      tick();
      chk("wait_valid", 32'(out_valid[0]), 32'd1);
      chk("wait_data", out_data[0], 32'd7);
      grant(4'd1);

      do_issue(1'b1, 32'd0, 32'd1, 4'd0, 4'd0, 4'd1, 32'hFFFF_FFFF, 1'b1, "sub_wrap");
      tick();
      tick();
      chk("wrap_data", out_data[0], 32'hFFFF_FFFF);
      grant(4'd1);

      // Entry 0 waits on qk=9; entry 1 issues with qj=9 while tag 9 broadcasts.
      do_issue(1'b0, 32'd1, 32'd0, 4'd0, 4'd9, 4'd1, 32'd5, 1'b1, "snoop_wait");
      bcast(4'd9, 32'd4);
      do_issue(1'b0, 32'd0, 32'd6, 4'd9, 4'd0, 4'd2, 32'd10, 1'b1, "bypass");
      bcast_off();
      tick();
      chk("bypass_lat2", 32'(out_valid[1]), 32'd0);
      tick();
      chk("bypass_valid", 32'(out_valid[1]), 32'd1);
      chk("snoop_valid", 32'(out_valid[0]), 32'd1);
      grant(4'd1);
      chk("partial_grant_e0", 32'(out_valid[0]), 32'd0);
      chk("partial_hold_valid", 32'(out_valid[1]), 32'd1);
      chk("partial_hold_data", out_data[1], 32'd10);
      tick();
      chk("partial_hold_valid2", 32'(out_valid[1]), 32'd1);
      chk("partial_hold_otag2", 32'(out_tag[1]), 32'd2);
      grant(4'd2);
      chk("partial_grant_e1", 32'(out_valid[1]), 32'd0);

      // Fill the station; a fourth issue is dropped.
      do_issue(1'b0, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, 32'd2, 1'b1, "fill0");
      do_issue(1'b0, 32'd2, 32'd2, 4'd0, 4'd0, 4'd2, 32'd4, 1'b1, "fill1");
      do_issue(1'b0, 32'd3, 32'd3, 4'd0, 4'd0, 4'd3, 32'd6, 1'b1, "fill2");
      chk("full_ready", 32'(issue_ready), 32'd0);
      chk("full_tag", 32'(issue_tag), 32'd0);
      issue_valid = 1'b1;
      issue_vj    = 32'd100;
      issue_vk    = 32'd100;
      tick();
      issue_valid = 1'b0;
      chk("full_ignored_ready", 32'(issue_ready), 32'd0);
      tick();
      for (int i = 0; i < N; i++) chk($sformatf("full_all_done%0d", i), 32'(out_valid[i]), 32'd1);
      grant(4'd2);
      chk("free_mid_valid", 32'(out_valid[1]), 32'd0);
      chk("free_mid_ready", 32'(issue_ready), 32'd1);
      chk("free_mid_tag", 32'(issue_tag), 32'd2);
      do_issue(1'b0, 32'd7, 32'd8, 4'd0, 4'd0, 4'd2, 32'd15, 1'b1, "refill");
      grant(4'd1);
      grant(4'd3);
      chk("refill_valid", 32'(out_valid[1]), 32'd1);
      chk("refill_data", out_data[1], 32'd15);
      chk("refill_next_tag", 32'(issue_tag), 32'd1);
      grant(4'd2);

      // Reset with entries in DONE, WAIT and EXEC.
      do_issue(1'b0, 32'd2, 32'd2, 4'd0, 4'd0, 4'd1, 32'd4, 1'b1, "pre_rst0");
      do_issue(1'b0, 32'd0, 32'd1, 4'd9, 4'd0, 4'd2, 32'd0, 1'b0, "pre_rst1");
      do_issue(1'b0, 32'd5, 32'd5, 4'd0, 4'd0, 4'd3, 32'd0, 1'b0, "pre_rst2");
      chk("pre_rst_done", 32'(out_valid[0]), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_tag", 32'(issue_tag), 32'd1);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
         chk($sformatf("rst_data%0d", i), out_data[i], 32'd0);
         chk($sformatf("rst_otag%0d", i), 32'(out_tag[i]), 32'd0);
      end
      bcast(4'd9, 32'd50);
      tick();
      bcast_off();
      for (int c = 0; c < 4; c++) tick();
      for (int i = 0; i < N; i++) chk($sformatf("stale_valid%0d", i), 32'(out_valid[i]), 32'd0);
      chk("stale_ready_tag", 32'(issue_tag), 32'd1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_rs.md
# add_rs

Adder reservation station for the Tomasulo core. It accepts issued add/sub instructions and holds them until their operands arrive on the common data bus. It then executes them and presents each result, with its tag, to the CDB arbiter on a per-entry adder output port. Because the CDB has no grant signal, each entry treats seeing its own tag broadcast on the CDB as the grant, and holds its result until then.

## Interface
Clocking: one clock (`clk`); reset `rst` is synchronous and active-high.

Parameters:
- `NUM_ENTRIES`, default 3: number of entries, one per CDB adder port.
- `TAG_BASE`, default 1: tag of entry 0. Entry i owns tag `TAG_BASE+i`.
- `EXEC_CYCLES`, default 2: execution cycles, must be ≥1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous active-high reset.
- `issue_valid`  in  1: issue request this cycle.
- `issue_op`  in  1: 0 = add, 1 = sub.
- `issue_vj`, `issue_vk`  in  32: operand values, used when the matching q field is 0.
- `issue_qj`, `issue_qk`  in  4: producer tags; 0 = value already valid.
- `issue_ready`  out  1: at least one entry is FREE.
- `issue_tag`  out  4: tag allocated if issue happens this cycle; 0 when none free.
- `cdb_data`  in  32: CDB snoop data.
- `cdb_tag`  in  4: CDB snoop tag.
- `cdb_valid`  in  1: CDB snoop valid.
- `out_data[NUM_ENTRIES]`  out  32: per-entry result to CDB adderN_data.
- `out_tag[NUM_ENTRIES]`  out  4: per-entry tag to CDB adderN_tag.
- `out_valid[NUM_ENTRIES]`  out  1: per-entry result valid to CDB adderN_valid.

## Operation
- Each entry has state FREE, WAIT, EXEC or DONE, plus op, vj, vk, qj, qk, an execution counter and a result register.
- **Allocation**
  - The lowest-index FREE entry, judged from registered state, is allocated.
  - Issue happens when `issue_valid && issue_ready`. If `issue_valid` is high with `issue_ready` low, the request is ignored and no state changes.
- **Issue bypass:** if `cdb_valid` is high and `cdb_tag` equals a nonzero `issue_qj`/`issue_qk` in the issue cycle, the entry captures `cdb_data` and clears that q.
- **Snoop:** every WAIT entry compares each nonzero q against `cdb_tag` when `cdb_valid` is high. On a match it loads `cdb_data` into v and clears q. Both operands may match in the same cycle.
- **FREE → WAIT or EXEC**
  - On issue, the entry goes to EXEC if both q fields are 0 after bypass; otherwise it goes to WAIT.
  - Entering EXEC loads the counter with `EXEC_CYCLES-1`.
- **WAIT → EXEC:** taken at the edge where the post-snoop qj and qk are both 0.
- **EXEC → DONE**
  - The counter decrements each cycle. The entry goes to DONE at the edge after the counter reads 0.
  - The result register is loaded on that same edge: vj+vk for add, vj−vk for sub.
  - Arithmetic is 32-bit modulo 2^32; no overflow flag.
- **DONE**
  - `out_valid=1`, `out_data=result`, `out_tag=TAG_BASE+i`.
  - The entry holds until `cdb_valid && cdb_tag==TAG_BASE+i`, then goes to FREE at that edge.
- **Idle outputs:** when not in DONE, `out_valid=0`, `out_data=0` and `out_tag=0`.
- **Tag 0** is never a match target; `cdb_tag==0` is ignored.

## Timing
- **Reset values:** all entries FREE, all v/q/counter/result registers 0, `out_*`=0, `issue_ready=1`, `issue_tag=TAG_BASE`.
- **Reset mid-operation:** pending and DONE results are discarded, and no `out_valid` is seen in the cycle after `rst`.
- **Latency, operands ready at issue:** issue in cycle t → `out_valid` rises in cycle t+1+EXEC_CYCLES (t+3 at the default).
- **Latency, operand arriving later:** last CDB broadcast in cycle t → EXEC from t+1 → `out_valid` in t+1+EXEC_CYCLES.
- **Grant to free:** own tag on the CDB in cycle t → `out_valid=0` and entry FREE in t+1. The entry is not re-allocatable in cycle t itself.
- **Full station:** `issue_ready=0` and `issue_tag=0`.
- **Simultaneous events:** several entries in DONE assert `out_valid` together; CDB priority picks one and the others keep holding.
- **Same-cycle snoop and issue:** a CDB broadcast in the same cycle as issue is seen by both the bypass and existing WAIT entries.

## Structure
- **Shared `tomasulo_pkg`:** `TAG_W=4`, `DATA_W=32`, `NO_TAG='0`, `alu_op_e` {OP_ADD, OP_SUB}, `rs_state_e` {FREE, WAIT, EXEC, DONE}.
- **Sub-module `rs_entry`:** one entry containing the state machine, snoop/bypass logic, counter and ALU, with its own tag as an input.
- **Top level:** instantiates `NUM_ENTRIES` copies of `rs_entry` plus the lowest-free allocator.

## Test plan
- Reset, then issue add vj=5, vk=7, qj=qk=0 in cycle 1 → `issue_tag`=1; `out_valid[0]`=1, `out_data[0]`=12, `out_tag[0]`=1 in cycle 4. Drive CDB tag 1 → `out_valid[0]`=0 in the next cycle.
- Issue sub with qj=9, vk=3 → entry stays WAIT. CDB tag 9, data 10 → result 7 after `EXEC_CYCLES+1` cycles. Sub 0−1 → 0xFFFFFFFF.
- Issue with qj=9 while the CDB broadcasts tag 9, data 4 in the same cycle → bypass captured, entry enters EXEC directly.
- Fill all 3 entries → `issue_ready`=0, `issue_tag`=0, a 4th issue is ignored. Grant tag 2 → entry 1 frees the next cycle, and the next issue gets tag 2.
- Two entries in DONE, CDB grants only tag 1 → entry 1 (tag 2) keeps `out_valid` and its data unchanged until tag 2 appears.
- Assert `rst` while entries are in WAIT, EXEC and DONE → all outputs 0 and `issue_ready`=1 on the next cycle; a later broadcast of a stale tag has no effect.
